// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder for a unified instruction/data
// bus. Accepts one request at a time, waits WAIT_CYCLES cycles, then commits the
// write or returns read data together with a one-cycle Ready strobe. Misaligned
// and out-of-range accesses are rejected with AdrErr.
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        AdrErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Request captured at acceptance; the bus may change freely afterwards.
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            acc;
    logic [AW-1:0]   idx_c;
    logic [31:0]     wdata_c;
    logic            we_c;
    logic            err_c;
    logic            to_resp;
    logic            mem_we;
    logic [31:0]     mem_rd;

    // Select the live request on the accepting edge (needed when there are no
    // wait states) and the latched copy otherwise; decide when to respond.
    always_comb begin
        acc     = (state == S_IDLE) && Req;
        idx_c   = idx_q;
        wdata_c = wdata_q;
        we_c    = we_q;
        err_c   = err_q;
        if (acc) begin
            idx_c   = Adr[AW+1:2];
            wdata_c = WriteData;
            we_c    = MemWrite;
            err_c   = (Adr[1:0] != 2'b00) || (Adr[31:AW+2] != '0);
        end
        if (WAIT_CYCLES == 0) begin
            to_resp = acc;
        end else begin
            to_resp = (state == S_WAIT) && (cnt == TERM);
        end
        mem_we = to_resp && we_c && !err_c;
        mem_rd = mem[idx_c];
    end

    // Storage array: no reset, written only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_c] <= wdata_c;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            ReadData <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            AdrErr   <= 1'b0;
        end else begin
            Ready  <= 1'b0;
            AdrErr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        idx_q   <= idx_c;
                        wdata_q <= wdata_c;
                        we_q    <= we_c;
                        err_q   <= err_c;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                end
                S_RESP: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
            if (to_resp) begin
                state  <= S_RESP;
                Ready  <= 1'b1;
                AdrErr <= err_c;
                if (err_c) begin
                    ReadData <= '0;
                end else if (we_c) begin
                    ReadData <= wdata_c;
                end else begin
                    ReadData <= mem_rd;
                end
            end
        end
    end

endmodule
